// File: rtl/rtc_spi_pkg.sv
// Shared constants and FSM state type for the RTC epoch SPI initiator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rtc_spi_pkg;

  localparam int EPOCH_W     = 64;
  localparam int EPOCH_BYTES = 8;

  // Command bytes understood by the epoch controller on the RTC slave port.
  localparam logic [7:0] WRCMD_DEFAULT = 8'h01;
  localparam logic [7:0] RDCMD_DEFAULT = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rtc_spi_master_shifter.sv
// One SPI mode-0 byte, MSB first: sclk generation, miso sampling, mosi shifting.
// Latency: 16*CLK_DIV clk cycles from go to the byte_done cycle.
// Backpressure: none; the sequencer must not issue go while a byte is active.
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       go,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic          phase_end;

  assign phase_end = active && (div_cnt == DIV_LAST);
  // Last cycle of the low phase after bit 0: the sequencer moves on here.
  assign byte_done = phase_end && !sclk && (bit_cnt == 3'd7);

  // Half-period timing, rising-edge sampling, falling-edge shifting, and mosi preload.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_byte <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      if (go) begin
        // Bit 7 is already on mosi from the preload; sample as sclk rises.
        active  <= 1'b1;
        sclk    <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        rx_byte <= {rx_byte[6:0], miso};
      end else if (active) begin
        if (!phase_end) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          if (sclk) begin
            sclk <= 1'b0;
            // After bit 0 mosi simply holds until the next preload.
            if (bit_cnt != 3'd7) begin
              mosi  <= tx_sr[6];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
          end else if (bit_cnt == 3'd7) begin
            active <= 1'b0;
          end else begin
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
            rx_byte <= {rx_byte[6:0], miso};
          end
        end
      end
      // Preload puts the next byte's MSB on mosi ahead of its first rising edge.
      if (load) begin
        tx_sr <= tx_byte;
        mosi  <= tx_byte[7];
      end
    end
  end

endmodule

// File: rtl/rtc_spi_master.sv
// SPI initiator that writes or reads the RTC 64-bit epoch in one 9-byte frame.
// Latency: CLK_DIV*146 + 8*GAP_CYCLES cycles of ss low, then a one-cycle done.
// Backpressure: start is only accepted in IDLE; starts while busy are dropped.
module rtc_spi_master
  import rtc_spi_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         GAP_CYCLES = 8,
  parameter logic [7:0] WRCMD      = WRCMD_DEFAULT,
  parameter logic [7:0] RDCMD      = RDCMD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               rw,
  input  logic [EPOCH_W-1:0] i_epoch,
  output logic [EPOCH_W-1:0] o_epoch,
  output logic               busy,
  output logic               done,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic               ss
);

  localparam int            CMAX     = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int            CW       = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(EPOCH_BYTES);

  state_t             state;
  logic [CW-1:0]      div_cnt;
  logic [3:0]         byte_cnt;
  logic               rw_q;
  logic [EPOCH_W-1:0] tx_buf;
  logic [EPOCH_W-1:0] rx_acc;

  logic       accept;
  logic       sh_go;
  logic       sh_load;
  logic [7:0] sh_byte;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign accept  = (state == ST_IDLE) && start;
  assign sh_go   = ((state == ST_SETUP) && (div_cnt == DIV_LAST)) ||
                   ((state == ST_GAP)   && (div_cnt == GAP_LAST));
  assign sh_load = accept ||
                   ((state == ST_SHIFT) && byte_done && (byte_cnt != LAST_BYTE));
  // Reads clock out zero data bytes; writes stream the latched epoch MSB first.
  assign sh_byte = accept ? (rw ? WRCMD : RDCMD)
                          : (rw_q ? tx_buf[EPOCH_W-1 -: 8] : 8'h00);

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .tx_byte   (sh_byte),
    .go        (sh_go),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .rx_byte   (rx_byte),
    .byte_done (byte_done)
  );

  // Frame sequencer: byte/gap ordering, ss, busy/done and epoch assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      byte_cnt <= '0;
      rw_q     <= 1'b0;
      tx_buf   <= '0;
      rx_acc   <= '0;
      ss       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      o_epoch  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETUP;
            div_cnt  <= '0;
            byte_cnt <= '0;
            rw_q     <= rw;
            tx_buf   <= i_epoch;
            ss       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (div_cnt == DIV_LAST) begin
            state   <= ST_SHIFT;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (byte_done) begin
            div_cnt <= '0;
            // The byte clocked in alongside the command carries no data.
            if (!rw_q && (byte_cnt != 4'd0)) begin
              rx_acc <= {rx_acc[EPOCH_W-9:0], rx_byte};
            end
            if (byte_cnt == LAST_BYTE) begin
              state <= ST_HOLD;
            end else begin
              state    <= ST_GAP;
              byte_cnt <= byte_cnt + 1'b1;
              if (rw_q) begin
                tx_buf <= {tx_buf[EPOCH_W-9:0], 8'h00};
              end
            end
          end
        end
        ST_GAP: begin
          if (div_cnt == GAP_LAST) begin
            state   <= ST_SHIFT;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (div_cnt == DIV_LAST) begin
            state   <= ST_DONE;
            div_cnt <= '0;
            ss      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            if (!rw_q) begin
              o_epoch <= rx_acc;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          div_cnt <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_spi_master.sv
// Directed bench for rtc_spi_master: framing, read assembly, timing, busy, reset, back-to-back.
// Instance a uses CLK_DIV=2/GAP=4 with a mode-0 slave model; instance b uses CLK_DIV=3/GAP=8.
// Expected values are hand-computed constants from the frame description.
module tb_rtc_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start_a = 1'b0;
  logic        rw_a = 1'b0;
  logic [63:0] i_epoch_a = '0;
  logic [63:0] o_epoch_a;
  logic        busy_a, done_a, sclk_a, mosi_a, ss_a;
  logic        miso_a = 1'b0;

  logic        start_b = 1'b0;
  logic        rw_b = 1'b1;
  logic [63:0] i_epoch_b = 64'hA5A5_5A5A_0F0F_F0F0;
  logic [63:0] o_epoch_b;
  logic        busy_b, done_b, sclk_b, mosi_b, ss_b;
  logic        miso_b = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rtc_spi_master #(.CLK_DIV(2), .GAP_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .rw(rw_a), .i_epoch(i_epoch_a),
    .o_epoch(o_epoch_a), .busy(busy_a), .done(done_a), .sclk(sclk_a),
    .mosi(mosi_a), .miso(miso_a), .ss(ss_a)
  );

  rtc_spi_master #(.CLK_DIV(3), .GAP_CYCLES(8)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .rw(rw_b), .i_epoch(i_epoch_b),
    .o_epoch(o_epoch_b), .busy(busy_b), .done(done_b), .sclk(sclk_b),
    .mosi(mosi_b), .miso(miso_b), .ss(ss_b)
  );

  // Monitor and slave state for instance a.
  logic        mon_clr = 1'b0;
  logic        prev_sclk_a = 1'b0;
  logic        prev_ss_a = 1'b1;
  logic [63:0] prev_oe = '0;
  int          rise_cnt = 0, ss_low_cnt = 0, done_cnt = 0;
  int          ss_hi_run = 0, last_ss_hi = 0, bitidx = 0;
  logic        ss_rise_err = 1'b0, oe_bad = 1'b0;
  logic [71:0] mosi_cap = '0;
  logic [63:0] done_epoch = '0;
  logic [71:0] slave_tx = {8'hFF, 64'hDEAD_BEEF_0000_0001};

  // Observe instance a on falling clk edges and act as its mode-0 slave.
  always @(negedge clk) begin
    prev_sclk_a <= sclk_a;
    prev_ss_a   <= ss_a;
    prev_oe     <= o_epoch_a;
    if (mon_clr) begin
      rise_cnt    <= 0;
      ss_low_cnt  <= 0;
      done_cnt    <= 0;
      ss_rise_err <= 1'b0;
      oe_bad      <= 1'b0;
    end else begin
      if (sclk_a && !prev_sclk_a) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[70:0], mosi_a};
        if (ss_a) ss_rise_err <= 1'b1;
      end
      if (!ss_a) ss_low_cnt <= ss_low_cnt + 1;
      if (done_a) begin
        done_cnt   <= done_cnt + 1;
        done_epoch <= o_epoch_a;
      end
      if (!done_a && (o_epoch_a !== prev_oe)) oe_bad <= 1'b1;
    end
    if (ss_a) begin
      ss_hi_run <= ss_hi_run + 1;
    end else begin
      if (ss_hi_run > 0) last_ss_hi <= ss_hi_run;
      ss_hi_run <= 0;
    end
    if (!ss_a && prev_ss_a) begin
      bitidx <= 0;
      miso_a <= slave_tx[71];
    end else if (!ss_a && prev_sclk_a && !sclk_a && (bitidx < 71)) begin
      bitidx <= bitidx + 1;
      miso_a <= slave_tx[70 - bitidx];
    end
  end

  // Phase-length monitor for instance b.
  int lo_run_b = 0, hi_run_b = 0, n_low3 = 0, n_gap = 0, n_bad_lo = 0;
  int n_high3 = 0, n_bad_hi = 0, tail_b = 0, ss_low_b = 0;

  always @(negedge clk) begin
    if (mon_clr) begin
      lo_run_b <= 0; hi_run_b <= 0; n_low3 <= 0; n_gap <= 0; n_bad_lo <= 0;
      n_high3 <= 0; n_bad_hi <= 0; tail_b <= 0; ss_low_b <= 0;
    end else if (!ss_b) begin
      ss_low_b <= ss_low_b + 1;
      if (sclk_b) begin
        hi_run_b <= hi_run_b + 1;
        if (lo_run_b > 0) begin
          if (lo_run_b == 3) n_low3 <= n_low3 + 1;
          else if (lo_run_b == 11) n_gap <= n_gap + 1;
          else n_bad_lo <= n_bad_lo + 1;
          lo_run_b <= 0;
        end
      end else begin
        lo_run_b <= lo_run_b + 1;
        if (hi_run_b > 0) begin
          if (hi_run_b == 3) n_high3 <= n_high3 + 1;
          else n_bad_hi <= n_bad_hi + 1;
          hi_run_b <= 0;
        end
      end
    end else if ((lo_run_b > 0) || (hi_run_b > 0)) begin
      tail_b   <= lo_run_b;
      lo_run_b <= 0;
      hi_run_b <= 0;
    end
  end

  task automatic clr_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic start_a_pulse(input logic r, input logic [63:0] e);
    @(negedge clk);
    start_a = 1'b1; rw_a = r; i_epoch_a = e;
    @(negedge clk);
    start_a = 1'b0;
    #1;
  endtask

  task automatic wait_done_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_a) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ss_a !== 1'b1) begin failures++; $display("FAIL rst_ss got=%b exp=1", ss_a); end
    checks++; if (sclk_a !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b exp=0", sclk_a); end
    checks++; if (mosi_a !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b exp=0", mosi_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done_a); end
    checks++; if (o_epoch_a !== 64'h0) begin failures++; $display("FAIL rst_oepoch got=%h exp=0", o_epoch_a); end
    checks++; if (ss_b !== 1'b1) begin failures++; $display("FAIL rst_ss_b got=%b exp=1", ss_b); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    bit ok;
    clr_mon();
    start_a_pulse(1'b1, 64'h0123_4567_89AB_CDEF);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy_a); end
    wait_done_a(ok);
    checks++; if (!ok) begin failures++; $display("FAIL wr_timeout got=none exp=done"); end
    checks++; if (mosi_cap !== 72'h01_0123_4567_89AB_CDEF) begin failures++; $display("FAIL wr_mosi got=%h exp=010123456789abcdef", mosi_cap); end
    checks++; if (rise_cnt != 72) begin failures++; $display("FAIL wr_rises got=%0d exp=72", rise_cnt); end
    checks++; if (ss_rise_err !== 1'b0) begin failures++; $display("FAIL wr_ss_at_rise got=%b exp=0", ss_rise_err); end
    checks++; if (ss_low_cnt != 324) begin failures++; $display("FAIL wr_ss_low got=%0d exp=324", ss_low_cnt); end
    checks++; if (o_epoch_a !== 64'h0) begin failures++; $display("FAIL wr_oepoch got=%h exp=0", o_epoch_a); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL wr_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_read();
    bit ok;
    clr_mon();
    start_a_pulse(1'b0, 64'hFFFF_0000_FFFF_0000);
    wait_done_a(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_timeout got=none exp=done"); end
    checks++; if (mosi_cap !== 72'h02_0000_0000_0000_0000) begin failures++; $display("FAIL rd_mosi got=%h exp=020000000000000000", mosi_cap); end
    checks++; if (done_epoch !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL rd_epoch_at_done got=%h exp=deadbeef00000001", done_epoch); end
    checks++; if (oe_bad !== 1'b0) begin failures++; $display("FAIL rd_oepoch_early got=%b exp=0", oe_bad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL rd_done_cnt got=%0d exp=1", done_cnt); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timing();
    bit ok;
    clr_mon();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    #1;
    checks++; if (!ok) begin failures++; $display("FAIL tm_timeout got=none exp=done"); end
    checks++; if (ss_low_b != 502) begin failures++; $display("FAIL tm_ss_low got=%0d exp=502", ss_low_b); end
    checks++; if (n_high3 != 72 || n_bad_hi != 0) begin failures++; $display("FAIL tm_high got=%0d/%0d exp=72/0", n_high3, n_bad_hi); end
    checks++; if (n_low3 != 64 || n_bad_lo != 0) begin failures++; $display("FAIL tm_low got=%0d/%0d exp=64/0", n_low3, n_bad_lo); end
    checks++; if (n_gap != 8) begin failures++; $display("FAIL tm_gaps got=%0d exp=8", n_gap); end
    checks++; if (tail_b != 6) begin failures++; $display("FAIL tm_hold got=%0d exp=6", tail_b); end
  endtask

  task automatic test_start_busy();
    bit ok;
    clr_mon();
    start_a_pulse(1'b1, 64'h1122_3344_5566_7788);
    repeat (49) @(negedge clk);
    start_a = 1'b1; rw_a = 1'b0; i_epoch_a = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bz_timeout got=none exp=done"); end
    checks++; if (mosi_cap !== 72'h01_1122_3344_5566_7788) begin failures++; $display("FAIL bz_mosi got=%h exp=011122334455667788", mosi_cap); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bz_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (busy_a !== 1'b0 || ss_a !== 1'b1) begin failures++; $display("FAIL bz_idle got=busy%b/ss%b exp=busy0/ss1", busy_a, ss_a); end
    start_a_pulse(1'b0, 64'h0);
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL bz_restart got=%b exp=1", busy_a); end
    wait_done_a(ok);
    checks++; if (done_epoch !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL bz_rd_epoch got=%h exp=deadbeef00000001", done_epoch); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    clr_mon();
    start_a_pulse(1'b0, 64'h0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (rise_cnt >= 44) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL mr_reach_byte5 got=%0d exp=44", rise_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ss_a !== 1'b1 || sclk_a !== 1'b0) begin failures++; $display("FAIL mr_lines got=ss%b/sclk%b exp=ss1/sclk0", ss_a, sclk_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", busy_a); end
    checks++; if (o_epoch_a !== 64'h0) begin failures++; $display("FAIL mr_oepoch got=%h exp=0", o_epoch_a); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL mr_no_done got=%0d exp=0", done_cnt); end
    clr_mon();
    start_a_pulse(1'b0, 64'h0);
    wait_done_a(ok);
    checks++; if (!ok || done_epoch !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL mr_reread got=%h exp=deadbeef00000001", done_epoch); end
    checks++; if (mosi_cap !== 72'h02_0000_0000_0000_0000) begin failures++; $display("FAIL mr_mosi got=%h exp=020000000000000000", mosi_cap); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clr_mon();
    start_a_pulse(1'b1, 64'hCAFE_F00D_1234_5678);
    wait_done_a(ok);
    checks++; if (!ok || mosi_cap !== 72'h01_CAFE_F00D_1234_5678) begin failures++; $display("FAIL bb_first got=%h exp=01cafef00d12345678", mosi_cap); end
    @(negedge clk);
    start_a = 1'b1; rw_a = 1'b0; i_epoch_a = 64'h0;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bb_timeout got=none exp=done"); end
    checks++; if (last_ss_hi != 2) begin failures++; $display("FAIL bb_ss_high got=%0d exp=2", last_ss_hi); end
    checks++; if (mosi_cap !== 72'h02_0000_0000_0000_0000) begin failures++; $display("FAIL bb_second_mosi got=%h exp=020000000000000000", mosi_cap); end
    checks++; if (done_epoch !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL bb_second_epoch got=%h exp=deadbeef00000001", done_epoch); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL bb_done_cnt got=%0d exp=2", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timing();
    test_start_busy();
    test_reset_mid_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
